fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
Instruction-fetch front end and the consumer of the branch comparator's taken/not-taken result. It owns the PC and issues word fetches to instruction memory over a req/ack handshake. It presents one buffered instruction to decode. On a taken branch or jump it redirects the PC, flushes younger stages and discards any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
TRAP_VECTOR, 32'h0000_0100, redirect target on misaligned branch target (optional feature only)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
branch_valid  in  1  execute stage holds a resolved conditional branch this cycle
branch_taken  in  1  comparator result (1 = taken); ignored unless branch_valid
jump_valid  in  1  unconditional JAL/JALR resolved this cycle
branch_target  in  32  redirect target for branch_valid or jump_valid
stall  in  1  decode cannot accept the buffered instruction
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address, stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  in  32  fetched instruction word
if_valid  out  1  if_instr/if_pc hold a valid instruction for decode
if_pc  out  32  PC of if_instr
if_instr  out  32  buffered instruction
flush  out  1  one-cycle pulse, cycle after redirect; decode/execute squash contents
misalign_trap  out  1  one-cycle pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=ISSUE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, flush=0, misalign_trap=0. rst overrides all inputs, including mid-fetch; a late imem_ack after reset is ignored.
- redirect = jump_valid | (branch_valid & branch_taken). branch_valid with branch_taken=0 changes nothing.
- Single entry fetch buffer (if_*); at most one outstanding request.
- States:
  - ISSUE: imem_req=1, imem_addr=pc. Enter only when the buffer will be free, i.e. if_valid=0 or stall=0. Go to WAIT.
  - WAIT: hold req/addr. On imem_ack: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0). Then go to ISSUE if the buffer will be free, else HOLD.
  - HOLD: no request; if_* stable while stall=1. When stall=0, go to ISSUE.
  - DISCARD: request outstanding but stale. Hold req/addr. On imem_ack drop data, then go to ISSUE with pc=redirect target.
- Decode consumes the buffer on any cycle with if_valid=1 and stall=0. if_valid drops the next cycle unless a new ack refills it that same cycle.
- Redirect has priority over stall and ack. In the redirect cycle:
  - pc<=target, if_valid<=0, flush<=1 for the next cycle.
  - WAIT without ack -> DISCARD.
  - WAIT with ack in the same cycle -> data dropped, go to ISSUE.
  - ISSUE/HOLD -> ISSUE. ISSUE was already asserting req this cycle, so it is treated as WAIT: go to DISCARD.
- Redirect while in DISCARD: pc updated to the new target, stay DISCARD; flush pulses again.
- Fetch-to-if_valid latency: imem_req rises 1 cycle after entering ISSUE; if_valid rises 1 cycle after imem_ack. Redirect-to-new-imem_addr: 1 cycle, or 1 cycle after the stale ack.
- Back-to-back fetch: a new request starts the cycle after ack when not stalled.

Optional Feature:
BRANCH_MISALIGN_TRAP_EN
- Defined: on redirect with branch_target[1:0]!=0, pc<=TRAP_VECTOR instead of the target, misalign_trap and flush pulse for one cycle the next cycle, and the same discard rules apply.
- Undefined: branch_target[1:0] forced to 2'b00 on redirect; misalign_trap tied 0.

Test Plan:
- Reset then 3 acks with 0 wait (rdata 0x13, 0x93, 0x113), stall=0 -> imem_addr 0x0,0x4,0x8; if_pc/if_instr 0x0/0x13, 0x4/0x93, 0x8/0x113; if_valid continuous after first.
- branch_valid=1, branch_taken=0, target 0x40 -> no flush, pc sequence unchanged.
- branch_valid=1, branch_taken=1, target 0x200 while WAIT at 0x10, ack 2 cycles later with 0xDEAD -> flush pulse; 0xDEAD never on if_instr; next imem_addr 0x200.
- stall=1 for 4 cycles with buffer full at pc 0x8 -> imem_req stays 0, if_instr stable; stall=0 -> req for 0xC next cycle.
- jump_valid=1 and imem_ack in same cycle, target 0x80 -> acked data dropped, if_valid=0, next imem_addr 0x80.
- With BRANCH_MISALIGN_TRAP_EN, taken target 0x202 -> misalign_trap=1 one cycle, next imem_addr 0x100; without the macro -> next imem_addr 0x200.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: owns the PC, fetches over imem req/ack, buffers one
// instruction for decode and redirects on taken branch/jump. Option: BRANCH_MISALIGN_TRAP_EN.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic        jump_valid,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush,
    output logic        misalign_trap
);

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_flush;
    logic        r_trap;

    logic        w_redirect;
    logic        w_misalign;
    logic        w_consume;
    logic [31:0] w_aligned;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_redirect = jump_valid | (branch_valid & branch_taken);
    assign w_consume  = r_if_valid & ~stall;
    assign w_pc_inc   = r_pc + 32'd4;
    assign w_aligned  = {branch_target[31:2], branch_target[1:0] & 2'b00};

`ifdef BRANCH_MISALIGN_TRAP_EN
    assign w_misalign = (branch_target[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_target = w_misalign ? TRAP_VECTOR : w_aligned;

    // Fetch sequencer. Entering ISSUE from WAIT/HOLD/DISCARD launches the request on
    // the same edge, so back-to-back fetches need no idle cycle; the ISSUE state
    // itself only exists for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ISSUE;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'h0000_0000;
            r_if_instr <= 32'h0000_0000;
            r_flush    <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            r_flush <= w_redirect;
            r_trap  <= w_redirect & w_misalign;
            if (w_redirect) begin
                r_if_valid <= 1'b0;
                r_pc       <= w_target;
                case (r_state)
                    ST_ISSUE: begin
                        // The old-PC request goes out anyway and must be discarded.
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                        r_state <= ST_DISCARD;
                    end
                    ST_WAIT, ST_DISCARD: begin
                        if (imem_ack) begin
                            r_req   <= 1'b1;
                            r_addr  <= w_target;
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end
                    default: begin
                        r_req   <= 1'b1;
                        r_addr  <= w_target;
                        r_state <= ST_WAIT;
                    end
                endcase
            end else begin
                if (w_consume) begin
                    r_if_valid <= 1'b0;
                end
                case (r_state)
                    ST_ISSUE: begin
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (imem_ack) begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_pc;
                            r_if_instr <= imem_rdata;
                            r_pc       <= w_pc_inc;
                            // Only prefetch when decode is moving, so the new word has room.
                            if (!stall) begin
                                r_addr  <= w_pc_inc;
                                r_state <= ST_WAIT;
                            end else begin
                                r_req   <= 1'b0;
                                r_state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            r_req   <= 1'b1;
                            r_addr  <= r_pc;
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_DISCARD: begin
                        if (imem_ack) begin
                            r_addr  <= r_pc;
                            r_state <= ST_WAIT;
                        end
                    end
                    default: begin
                        r_req   <= 1'b0;
                        r_state <= ST_ISSUE;
                    end
                endcase
            end
        end
    end

    assign imem_req      = r_req;
    assign imem_addr     = r_addr;
    assign if_valid      = r_if_valid;
    assign if_pc         = r_if_pc;
    assign if_instr      = r_if_instr;
    assign flush         = r_flush;
    assign misalign_trap = r_trap;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural reference model.
module tb_fetch_redirect_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] TV  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, branch_valid, branch_taken, jump_valid, stall, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, if_valid, flush, misalign_trap;
    logic [31:0] imem_addr, if_pc, if_instr;

    always #5 clk = ~clk;

    fetch_redirect_unit #(.RESET_PC(RPC), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .branch_valid(branch_valid), .branch_taken(branch_taken),
        .jump_valid(jump_valid), .branch_target(branch_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .flush(flush), .misalign_trap(misalign_trap)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: outstanding request, its staleness, the decode buffer and the PC
    bit          m_req, m_stale, m_hold, m_boot, m_buf_v, m_flush, m_trap, m_issued;
    logic [31:0] m_pc, m_addr, m_buf_pc, m_buf_ins;
    int          mem_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_req = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
        m_pc = RPC; m_addr = RPC; m_buf_v = 1'b0; m_buf_pc = 32'h0; m_buf_ins = 32'h0;
        m_flush = 1'b0; m_trap = 1'b0; m_issued = 1'b0;
    endtask

    task automatic model_step();
        bit          redirect, mis, got;
        logic [31:0] eff;
        redirect = jump_valid || (branch_valid && branch_taken);
`ifdef BRANCH_MISALIGN_TRAP_EN
        mis = (branch_target & 32'h3) != 32'h0;
`else
        mis = 1'b0;
`endif
        eff      = mis ? TV : (branch_target & ~32'h3);
        got      = m_req && imem_ack;
        m_issued = 1'b0;
        m_flush  = redirect;
        m_trap   = redirect && mis;
        if (redirect) begin
            m_buf_v = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0; m_req = 1'b1; m_addr = m_pc; m_stale = 1'b1; m_issued = 1'b1;
            end else if (m_req && !got) begin
                m_stale = 1'b1;
            end else begin
                m_req = 1'b1; m_addr = eff; m_stale = 1'b0; m_hold = 1'b0; m_issued = 1'b1;
            end
            m_pc = eff;
        end else begin
            if (m_buf_v && !stall) m_buf_v = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0; m_req = 1'b1; m_addr = m_pc; m_issued = 1'b1;
            end else if (got && m_stale) begin
                m_stale = 1'b0; m_addr = m_pc; m_issued = 1'b1;
            end else if (got) begin
                m_buf_v = 1'b1; m_buf_pc = m_pc; m_buf_ins = imem_rdata; m_pc = m_pc + 32'd4;
                if (!stall) begin
                    m_addr = m_pc; m_issued = 1'b1;
                end else begin
                    m_req = 1'b0; m_hold = 1'b1;
                end
            end else if (m_hold && !stall) begin
                m_hold = 1'b0; m_req = 1'b1; m_addr = m_pc; m_issued = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk1("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_addr);
        chk1("if_valid", if_valid, m_buf_v);
        chk("if_pc", if_pc, m_buf_pc);
        chk("if_instr", if_instr, m_buf_ins);
        chk1("flush", flush, m_flush);
        chk1("misalign_trap", misalign_trap, m_trap);
    endtask

    task automatic cyc(input bit bv, input bit bt, input bit jv, input logic [31:0] tgt,
                       input bit st, input bit ack, input logic [31:0] rd);
        branch_valid = bv; branch_taken = bt; jump_valid = jv; branch_target = tgt;
        stall = st; imem_ack = ack; imem_rdata = rd;
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        bit          a;
        int          r;
        logic [31:0] t;
        logic [31:0] exp_mis;
`ifdef BRANCH_MISALIGN_TRAP_EN
        exp_mis = 32'h0000_0100;
`else
        exp_mis = 32'h0000_0200;
`endif
        rst = 1'b1;
        mem_cnt = 0;
        #1;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 32'hBAD0_0000);
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RPC);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_flush", flush, 1'b0);
        rst = 1'b0;
        // late ack right after reset is ignored
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0001);
        chk("first_addr", imem_addr, 32'h0);
        chk1("late_ack_ignored", if_valid, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13);
        chk("seq_pc0", if_pc, 32'h0);
        chk("seq_addr4", imem_addr, 32'h4);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h93);
        chk("seq_instr1", if_instr, 32'h93);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h113);
        chk("seq_pc2", if_pc, 32'h8);
        chk("seq_addrC", imem_addr, 32'hC);
        chk1("seq_valid", if_valid, 1'b1);
        // not-taken branch changes nothing
        cyc(1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0);
        chk1("nt_flush", flush, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h193);
        chk("nt_addr", imem_addr, 32'h10);
        // taken branch while waiting at 0x10, stale ack two cycles later
        cyc(1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0);
        chk1("tk_flush", flush, 1'b1);
        chk1("tk_if_valid", if_valid, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk1("tk_flush_end", flush, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD);
        chk("tk_new_addr", imem_addr, 32'h200);
        chk1("tk_no_dead", if_instr == 32'hDEAD, 1'b0);
        // stall with full buffer
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2222);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            chk1("stall_req", imem_req, 1'b0);
            chk("stall_instr", if_instr, 32'h2222);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk1("unstall_req", imem_req, 1'b1);
        chk("unstall_addr", imem_addr, 32'h208);
        // jump coinciding with ack
        cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h3333);
        chk1("jmp_if_valid", if_valid, 1'b0);
        chk("jmp_addr", imem_addr, 32'h80);
        // misaligned taken target
        cyc(1'b1, 1'b1, 1'b0, 32'h202, 1'b0, 1'b0, 32'h0);
`ifdef BRANCH_MISALIGN_TRAP_EN
        chk1("mis_trap", misalign_trap, 1'b1);
`else
        chk1("mis_trap", misalign_trap, 1'b0);
`endif
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555);
        chk("mis_addr", imem_addr, exp_mis);
        // PC wrap
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h6666);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4444);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // random phase: memory acks after 0..3 cycles of latency
        mem_cnt = $urandom_range(0, 3);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            a = m_req && (mem_cnt == 0);
            if (m_req && mem_cnt > 0) mem_cnt--;
            r = $urandom_range(0, 99);
            t = $urandom & 32'h0000_0FFF;
            cyc(r < 8, $urandom_range(0, 1) == 1, (r >= 8) && (r < 12), t,
                $urandom_range(0, 99) < 30, a, $urandom);
            if (m_issued) mem_cnt = $urandom_range(0, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
